// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing source for the TinyVGA output path. Produces 640x480@60 Hz
//   (by default) sync, blanking and pixel coordinates from one clock, plus
//   line/frame strobes and a frame counter for motion timing.
//
//   Optional feature macro: VGA_PIXDIV_EN
//     defined   : internal toggle register produces a pixel enable every
//                 other clock (50 MHz boards). All timing outputs hold for
//                 both clocks of a pixel period.
//     undefined : one pixel per clock, o_pix_en tied high.
//
// Ports
//   i_clk          sole clock
//   i_reset        asynchronous, active-high reset
//   o_hsync        horizontal sync, active low
//   o_vsync        vertical sync, active low
//   o_display_on   high inside the visible area
//   o_hpos         current pixel column, 0..H_TOTAL-1
//   o_vpos         current line, 0..V_TOTAL-1
//   o_line_start   high for the pixel period with hpos==0 (not the first after reset)
//   o_frame_start  high for the pixel period at (0,0) (not the first after reset)
//   o_frame_count  frames completed since reset, modulo 256
//   o_pix_en       high on clocks where the counters advance at the next edge
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic       i_clk,
   input  logic       i_reset,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic       o_display_on,
   output logic [9:0] o_hpos,
   output logic [9:0] o_vpos,
   output logic       o_line_start,
   output logic       o_frame_start,
   output logic [7:0] o_frame_count,
   output logic       o_pix_en
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
   localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
   localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

   logic       w_adv;
   logic       w_h_wrap;
   logic       w_v_wrap;
   logic       w_frame_wrap;
   logic [9:0] w_hpos_nxt;
   logic [9:0] w_vpos_nxt;

   logic       r_hsync;
   logic       r_vsync;
   logic       r_display_on;
   logic [9:0] r_hpos;
   logic [9:0] r_vpos;
   logic       r_line_start;
   logic       r_frame_start;
   logic [7:0] r_frame_count;

`ifdef VGA_PIXDIV_EN
   // Divide-by-2 pixel enable. Resets low so the first edge after release
   // only raises it; the counters first move on the second edge.
   logic r_pix_en;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_pix_en <= 1'b0;
      else         r_pix_en <= ~r_pix_en;
   end

   assign w_adv    = r_pix_en;
   assign o_pix_en = r_pix_en;
`else
   assign w_adv    = 1'b1;
   assign o_pix_en = 1'b1;
`endif

   assign w_h_wrap     = (r_hpos == H_LAST);
   assign w_v_wrap     = (r_vpos == V_LAST);
   assign w_frame_wrap = w_h_wrap & w_v_wrap;

   assign w_hpos_nxt = w_h_wrap ? 10'd0 : r_hpos + 10'd1;
   assign w_vpos_nxt = w_h_wrap ? (w_v_wrap ? 10'd0 : r_vpos + 10'd1) : r_vpos;

   // Sync, blanking and strobes are decoded from the next counter values so
   // that every registered output describes the same pixel as hpos/vpos.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_hpos        <= 10'd0;
         r_vpos        <= 10'd0;
         r_hsync       <= 1'b1;
         r_vsync       <= 1'b1;
         r_display_on  <= 1'b1;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_count <= 8'd0;
      end else if (w_adv) begin
         r_hpos        <= w_hpos_nxt;
         r_vpos        <= w_vpos_nxt;
         r_hsync       <= ~((w_hpos_nxt >= HS_START) && (w_hpos_nxt < HS_END));
         r_vsync       <= ~((w_vpos_nxt >= VS_START) && (w_vpos_nxt < VS_END));
         r_display_on  <= (w_hpos_nxt < H_VIS_W) && (w_vpos_nxt < V_VIS_W);
         r_line_start  <= w_h_wrap;
         r_frame_start <= w_frame_wrap;
         if (w_frame_wrap) r_frame_count <= r_frame_count + 8'd1;
      end
   end

   assign o_hsync       = r_hsync;
   assign o_vsync       = r_vsync;
   assign o_display_on  = r_display_on;
   assign o_hpos        = r_hpos;
   assign o_vpos        = r_vpos;
   assign o_line_start  = r_line_start;
   assign o_frame_start = r_frame_start;
   assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Scoreboard bench for vga_timing_gen using a shrunken raster so that
//   several hundred frames fit in a short run. Expected outputs come from a
//   closed-form model: the number of pixels advanced since reset release
//   determines column, line, strobes and frame count by division/modulo.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int HV = 4, HF = 2, HS = 2, HB = 2;
   localparam int VV = 2, VF = 1, VS = 2, VB = 1;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
`ifdef VGA_PIXDIV_EN
   localparam int DIV = 2;
`else
   localparam int DIV = 1;
`endif
   localparam int FRAME_CLK = HT * VT * DIV;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       hsync, vsync, display_on, line_start, frame_start, pix_en;
   logic [9:0] hpos, vpos;
   logic [7:0] frame_count;

   vga_timing_gen #(
      .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .o_hsync       (hsync),
      .o_vsync       (vsync),
      .o_display_on  (display_on),
      .o_hpos        (hpos),
      .o_vpos        (vpos),
      .o_line_start  (line_start),
      .o_frame_start (frame_start),
      .o_frame_count (frame_count),
      .o_pix_en      (pix_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      int hs, vs, de, h, v, ls, fs, fc, pe;
   } exp_t;

   exp_t exp_q[$];
   int   k = 0;          // clock edges counted since reset release
   int   n_chk = 0;
   int   n_fail = 0;

   // Reference: pixel index n = edges / DIV; everything else follows from n.
   function automatic exp_t model(input int kk);
      exp_t e;
      int   n;
      n    = kk / DIV;
      e.pe = (DIV == 2) ? (kk % 2) : 1;
      e.h  = n % HT;
      e.v  = (n / HT) % VT;
      e.fc = (n / (HT * VT)) % 256;
      e.hs = (e.h >= HV + HF && e.h < HV + HF + HS) ? 0 : 1;
      e.vs = (e.v >= VV + VF && e.v < VV + VF + VS) ? 0 : 1;
      e.de = (e.h < HV && e.v < VV) ? 1 : 0;
      e.ls = (n > 0 && e.h == 0) ? 1 : 0;
      e.fs = (n > 0 && e.h == 0 && e.v == 0) ? 1 : 0;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int want);
      n_chk++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
      end
   endtask

   // One clock of stimulus: wait for the edge, then (2 ns later, off-edge)
   // drive reset for the coming cycle and push the expected observation.
   task automatic cycle(input bit rst_next);
      bit rst_at_edge;
      rst_at_edge = reset;
      @(posedge clk);
      if (!rst_at_edge) k++;
      #2;
      reset = rst_next;
      if (rst_next) k = 0;
      exp_q.push_back(model(k));
   endtask

   // Monitor: every falling edge the DUT presents one observation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard: no expected entry at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("hpos",        int'(hpos),        e.h);
            chk("vpos",        int'(vpos),        e.v);
            chk("hsync",       int'(hsync),       e.hs);
            chk("vsync",       int'(vsync),       e.vs);
            chk("display_on",  int'(display_on),  e.de);
            chk("line_start",  int'(line_start),  e.ls);
            chk("frame_start", int'(frame_start), e.fs);
            chk("frame_count", int'(frame_count), e.fc);
            chk("pix_en",      int'(pix_en),      e.pe);
         end
      end
   end

   initial begin
      int   len;
      int   guard;
      exp_t cur;

      // Held in reset: outputs at reset values across several edges.
      repeat (3) cycle(1'b1);

      // Random run lengths interrupted by random-length async resets.
      for (int r = 0; r < 6; r++) begin
         len = $urandom_range(20, 400);
         repeat (len) cycle(1'b0);
         len = $urandom_range(1, 3);
         repeat (len) cycle(1'b1);
      end

      // Long run: past 256 frames so frame_count wraps through 0.
      len = 257 * FRAME_CLK + $urandom_range(0, 3 * HT * DIV);
      repeat (len) cycle(1'b0);

      // Reset while both syncs are low; they must return high at once and
      // the next frame must be a full frame from release.
      guard = 0;
      cur = model(k);
      while (!(cur.hs == 0 && cur.vs == 0) && guard < 2 * FRAME_CLK) begin
         cycle(1'b0);
         cur = model(k);
         guard++;
      end
      chk("reach_sync_overlap", (guard < 2 * FRAME_CLK) ? 1 : 0, 1);
      cycle(1'b1);
      repeat (2) cycle(1'b1);
      repeat (2 * FRAME_CLK + 7) cycle(1'b0);

      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
